// File: rtl/neuron_seq_pkg.sv
// Shared definitions for the neuron classification sequencer.
// Holds the FSM state encoding and the default image geometry.
package neuron_seq_pkg;

    // 64x64 pixels, one 24-bit word per pixel.
    localparam int DEFAULT_ADDR_DEPTH = 12;
    localparam int DEFAULT_NUM_WORDS  = 4096;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_STREAM  = 3'd2,
        S_DRAIN   = 3'd3,
        S_RESULT  = 3'd4,
        S_CAPTURE = 3'd5,
        S_DONE    = 3'd6
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
// Ports: clock, reset (sync, active-high), inc, clr, count[WIDTH-1:0].
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/neuron_sequencer.sv
// Runs one classification pass of the neuron calculator over an image.
// Ports: start/abort/hold/clear_stats in, memory read, calculator strobes, status and stats out.
module neuron_sequencer
    import neuron_seq_pkg::*;
#(
    parameter int ADDR_DEPTH = DEFAULT_ADDR_DEPTH,
    parameter int NUM_WORDS  = DEFAULT_NUM_WORDS,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  hold,
    input  logic                  clear_stats,
    output logic [ADDR_DEPTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  calc_reset,
    output logic                  calc_enable,
    output logic                  calc_get_result,
    input  logic                  calc_out,
    output logic                  busy,
    output logic                  done,
    output logic                  is_cat,
    output logic [STAT_WIDTH-1:0] image_count,
    output logic [STAT_WIDTH-1:0] cat_count
);

    // One extra bit so a full 2**ADDR_DEPTH image ends without wrapping.
    localparam logic [ADDR_DEPTH:0] LAST_ADDR = (ADDR_DEPTH+1)'(NUM_WORDS - 1);
    localparam logic [ADDR_DEPTH:0] END_ADDR  = (ADDR_DEPTH+1)'(NUM_WORDS);

    seq_state_t state;
    seq_state_t state_next;

    logic [ADDR_DEPTH:0] addr_cnt;
    logic                cnt_clr;
    logic                cnt_inc;
    logic                capture;

    // After the last issue the counter sits at NUM_WORDS; show 0 instead.
    assign mem_addr = (addr_cnt < END_ADDR) ? addr_cnt[ADDR_DEPTH-1:0] : '0;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            addr_cnt <= '0;
            is_cat   <= 1'b0;
        end else begin
            state <= state_next;
            if (cnt_clr) begin
                addr_cnt <= '0;
            end else if (cnt_inc) begin
                addr_cnt <= addr_cnt + 1'b1;
            end
            if (capture) begin
                is_cat <= calc_out;
            end
        end
    end

    always_comb begin
        state_next      = state;
        mem_rd          = 1'b0;
        calc_reset      = 1'b0;
        calc_enable     = 1'b0;
        calc_get_result = 1'b0;
        done            = 1'b0;
        cnt_clr         = 1'b0;
        cnt_inc         = 1'b0;
        capture         = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                calc_reset = 1'b1;
                cnt_clr    = 1'b1;
                state_next = S_STREAM;
            end
            S_STREAM: begin
                if (!hold) begin
                    mem_rd      = 1'b1;
                    calc_enable = 1'b1;
                    cnt_inc     = 1'b1;
                    if (addr_cnt == LAST_ADDR) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            // Last word is accumulated by the calculator in this cycle.
            S_DRAIN: begin
                state_next = S_RESULT;
            end
            S_RESULT: begin
                calc_get_result = 1'b1;
                state_next      = S_CAPTURE;
            end
            S_CAPTURE: begin
                capture    = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort overrides hold and progression, and silences every strobe.
        if (abort && (state != S_IDLE)) begin
            state_next      = S_IDLE;
            mem_rd          = 1'b0;
            calc_reset      = 1'b0;
            calc_enable     = 1'b0;
            calc_get_result = 1'b0;
            done            = 1'b0;
            cnt_clr         = 1'b0;
            cnt_inc         = 1'b0;
            capture         = 1'b0;
        end
    end

    sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_image_count (
        .clock (clock),
        .reset (reset),
        .inc   (capture),
        .clr   (clear_stats),
        .count (image_count)
    );

    sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_cat_count (
        .clock (clock),
        .reset (reset),
        .inc   (capture & calc_out),
        .clr   (clear_stats),
        .count (cat_count)
    );

endmodule
